// File: rtl/ntt_poly_buffer.sv
// Ping-pong store of sampler coefficients; streams each completed 256-entry polynomial in index order.
// Latency: N-th write at edge W -> poly_done after W, first rd_valid after W+1; 1-cycle bubble between banks.
// Backpressure: rd_ready stalls the stream with outputs held; writes are never stalled, only dropped outside W_FILL.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   wr_start            pulse: begin (or restart) filling the current fill bank
//   z_valid, z_in       sampler coefficient strobe and value (values >= Q are dropped)
//   wr_ready            high while coefficients are being accepted
//   poly_done           pulse after the N-th coefficient of a bank is stored
//   wr_count            coefficients stored in the current fill
//   overflow, range_err sticky error flags, cleared by wr_start
//   rd_valid/rd_ready   output handshake; rd_data/rd_idx/rd_last/rd_bank describe the coefficient
module ntt_poly_buffer #(
    parameter int N      = 256,
    parameter int IN_W   = 24,
    parameter int COEF_W = 23,
    parameter int Q      = 8380417
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_start,
    input  logic                  z_valid,
    input  logic [IN_W-1:0]       z_in,
    output logic                  wr_ready,
    output logic                  poly_done,
    output logic [$clog2(N):0]    wr_count,
    output logic                  overflow,
    output logic                  range_err,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [COEF_W-1:0]     rd_data,
    output logic [$clog2(N)-1:0]  rd_idx,
    output logic                  rd_last,
    output logic                  rd_bank
);
    localparam int AW = $clog2(N);

    typedef enum logic [1:0] {W_IDLE, W_WAIT, W_FILL} w_state_t;
    typedef enum logic       {R_IDLE, R_STREAM}       r_state_t;

    logic [COEF_W-1:0] mem [2][N];
    logic [1:0]        full;
    logic              fill_bank;
    logic              read_bank;
    w_state_t          w_state, w_next;
    r_state_t          r_state, r_next;

    logic          z_ok;
    logic          wr_accept;
    logic          wr_last;
    logic          rd_fire;
    logic          rd_end;
    logic          rd_load;
    logic [AW-1:0] rd_idx_nxt;

    assign z_ok       = z_in < IN_W'(Q);
    // wr_start takes priority over a coincident strobe: the fill restarts from zero.
    assign wr_accept  = !rst && (w_state == W_FILL) && !wr_start && z_valid && z_ok;
    assign wr_last    = wr_accept && (wr_count == (AW+1)'(N-1));
    assign rd_fire    = rd_valid && rd_ready;
    assign rd_end     = rd_fire && (rd_idx == AW'(N-1));
    assign rd_load    = (r_state == R_IDLE) && full[read_bank];
    assign rd_idx_nxt = rd_idx + 1'b1;

    // ---------------- write FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) w_state <= W_IDLE;
        else     w_state <= w_next;
    end

    always_comb begin
        w_next = w_state;
        if (wr_start) begin
            // Restart from any state re-uses the same fill bank.
            w_next = full[fill_bank] ? W_WAIT : W_FILL;
        end else begin
            case (w_state)
                W_WAIT:  if (!full[fill_bank]) w_next = W_FILL;
                W_FILL:  if (wr_last)          w_next = W_IDLE;
                default: ;
            endcase
        end
    end

    always_comb begin
        wr_ready = (w_state == W_FILL);
        rd_valid = (r_state == R_STREAM);
        rd_last  = rd_valid && (rd_idx == AW'(N-1));
        rd_bank  = read_bank;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_count  <= '0;
            overflow  <= 1'b0;
            range_err <= 1'b0;
            poly_done <= 1'b0;
            fill_bank <= 1'b0;
        end else begin
            poly_done <= wr_last;
            if (wr_start) begin
                wr_count  <= '0;
                overflow  <= 1'b0;
                range_err <= 1'b0;
            end else begin
                if (wr_accept)
                    wr_count <= wr_count + 1'b1;
                if ((w_state == W_FILL) && z_valid && !z_ok)
                    range_err <= 1'b1;
                if ((w_state == W_WAIT) && z_valid)
                    overflow <= 1'b1;
            end
            if (wr_last)
                fill_bank <= ~fill_bank;
        end
    end

    // Array is deliberately not reset; stale data is never exposed because
    // a bank is only read after a complete fill.
    always_ff @(posedge clk) begin
        if (wr_accept)
            mem[fill_bank][wr_count[AW-1:0]] <= z_in[COEF_W-1:0];
    end

    // Set and clear can target different banks in the same cycle; a bank is
    // never filled while full, so they never collide on one bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            full <= 2'b00;
        end else begin
            if (wr_last) full[fill_bank] <= 1'b1;
            if (rd_end)  full[read_bank] <= 1'b0;
        end
    end

    // ---------------- read FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) r_state <= R_IDLE;
        else     r_state <= r_next;
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:   if (full[read_bank]) r_next = R_STREAM;
            R_STREAM: if (rd_end)          r_next = R_IDLE;
            default:  ;
        endcase
    end

    // Registered read port: next coefficient is fetched on the handshake so
    // the stream sustains one coefficient per cycle and holds while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_bank <= 1'b0;
            rd_idx    <= '0;
            rd_data   <= '0;
        end else if (rd_load) begin
            rd_idx  <= '0;
            rd_data <= mem[read_bank][0];
        end else if (rd_end) begin
            read_bank <= ~read_bank;
        end else if (rd_fire) begin
            rd_idx  <= rd_idx_nxt;
            rd_data <= mem[read_bank][rd_idx_nxt];
        end
    end
endmodule

// File: tb/tb_ntt_poly_buffer.sv
// Self-checking bench for ntt_poly_buffer: a queue-based model of completed polynomials,
// a per-cycle compare process on the read stream, and directed literal checks.
module tb_ntt_poly_buffer;
    localparam int N = 256;
    localparam int Q = 8380417;

    logic        clk;
    logic        rst;
    logic        wr_start;
    logic        z_valid;
    logic [23:0] z_in;
    logic        rd_ready;
    logic        wr_ready;
    logic        poly_done;
    logic [8:0]  wr_count;
    logic        overflow;
    logic        range_err;
    logic        rd_valid;
    logic [22:0] rd_data;
    logic [7:0]  rd_idx;
    logic        rd_last;
    logic        rd_bank;

    ntt_poly_buffer dut (
        .clk       (clk),
        .rst       (rst),
        .wr_start  (wr_start),
        .z_valid   (z_valid),
        .z_in      (z_in),
        .wr_ready  (wr_ready),
        .poly_done (poly_done),
        .wr_count  (wr_count),
        .overflow  (overflow),
        .range_err (range_err),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_idx    (rd_idx),
        .rd_last   (rd_last),
        .rd_bank   (rd_bank)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: coefficients of completed-but-unread polynomials in order, with their banks.
    logic [22:0] exp_coef[$];
    bit          exp_bank[$];
    int          exp_pos;
    bit          exp_done;
    logic [22:0] m_cur[$];
    bit          m_fill;
    bit          m_fill_bank;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    function automatic bit bank_busy(input bit b);
        foreach (exp_bank[i])
            if (exp_bank[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_clear();
        exp_coef.delete();
        exp_bank.delete();
        m_cur.delete();
        exp_pos     = 0;
        exp_done    = 1'b0;
        m_fill      = 1'b0;
        m_fill_bank = 1'b0;
    endtask

    // Compare process: the stream must follow the model queue exactly.
    always @(negedge clk) begin
        if (!rst) begin
            check("poly_done", {31'd0, poly_done}, {31'd0, exp_done});
            exp_done = 1'b0;
            if (rd_valid) begin
                if (exp_coef.size() == 0) begin
                    check("rd_valid_unexpected", 32'd1, 32'd0);
                end else begin
                    check("rd_data", {9'd0, rd_data}, {9'd0, exp_coef[0]});
                    check("rd_idx", {24'd0, rd_idx}, exp_pos);
                    check("rd_bank", {31'd0, rd_bank}, {31'd0, exp_bank[0]});
                    check("rd_last", {31'd0, rd_last}, (exp_pos == N-1) ? 32'd1 : 32'd0);
                    if (rd_ready) begin
                        void'(exp_coef.pop_front());
                        exp_pos++;
                        if (exp_pos == N) begin
                            exp_pos = 0;
                            void'(exp_bank.pop_front());
                        end
                    end
                end
            end else begin
                check("rd_last_idle", {31'd0, rd_last}, 32'd0);
            end
        end
    end

    task automatic send(input logic [23:0] z);
        z_valid = 1'b1;
        z_in    = z;
        @(posedge clk); #1;
        z_valid = 1'b0;
        if (m_fill && (z < Q)) begin
            m_cur.push_back(z[22:0]);
            if (m_cur.size() == N) begin
                foreach (m_cur[i]) exp_coef.push_back(m_cur[i]);
                exp_bank.push_back(m_fill_bank);
                m_fill_bank = !m_fill_bank;
                m_cur.delete();
                m_fill   = 1'b0;
                exp_done = 1'b1;
            end
        end
    endtask

    task automatic start_fill(input string tag);
        bit busy;
        wr_start = 1'b1;
        @(posedge clk); #1;
        wr_start = 1'b0;
        m_cur.delete();
        busy   = bank_busy(m_fill_bank);
        m_fill = !busy;
        check({tag, "_wr_ready"}, {31'd0, wr_ready}, {31'd0, !busy});
        check({tag, "_wr_count0"}, {23'd0, wr_count}, 32'd0);
        check({tag, "_overflow0"}, {31'd0, overflow}, 32'd0);
        check({tag, "_range_err0"}, {31'd0, range_err}, 32'd0);
    endtask

    task automatic wait_drain(input string tag);
        int n = 0;
        while (exp_coef.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_drained"}, exp_coef.size(), 32'd0);
        @(negedge clk);
        check({tag, "_rd_idle"}, {31'd0, rd_valid}, 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        model_clear();
        @(posedge clk); #1;
        check({tag, "_rst_rd_valid"}, {31'd0, rd_valid}, 32'd0);
        check({tag, "_rst_rd_data"}, {9'd0, rd_data}, 32'd0);
        check({tag, "_rst_rd_idx"}, {24'd0, rd_idx}, 32'd0);
        check({tag, "_rst_rd_last"}, {31'd0, rd_last}, 32'd0);
        check({tag, "_rst_rd_bank"}, {31'd0, rd_bank}, 32'd0);
        check({tag, "_rst_wr_ready"}, {31'd0, wr_ready}, 32'd0);
        check({tag, "_rst_poly_done"}, {31'd0, poly_done}, 32'd0);
        check({tag, "_rst_wr_count"}, {23'd0, wr_count}, 32'd0);
        check({tag, "_rst_overflow"}, {31'd0, overflow}, 32'd0);
        check({tag, "_rst_range_err"}, {31'd0, range_err}, 32'd0);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        wr_start = 1'b0;
        z_valid  = 1'b0;
        z_in     = '0;
        rd_ready = 1'b0;
        model_clear();
        @(posedge clk); #1;
        do_reset("init");

        // T1: basic fill 0..255 and full-rate stream from bank 0.
        rd_ready = 1'b1;
        start_fill("t1");
        for (int i = 0; i < N; i++) send(24'(i));
        check("t1_poly_done_now", {31'd0, poly_done}, 32'd1);
        check("t1_rd_valid_early", {31'd0, rd_valid}, 32'd0);
        check("t1_wr_count_n", {23'd0, wr_count}, 32'd256);
        check("t1_wr_ready_low", {31'd0, wr_ready}, 32'd0);
        @(posedge clk); #1;
        check("t1_poly_done_gone", {31'd0, poly_done}, 32'd0);
        check("t1_rd_valid_rise", {31'd0, rd_valid}, 32'd1);
        check("t1_first_data", {9'd0, rd_data}, 32'd0);
        check("t1_first_idx", {24'd0, rd_idx}, 32'd0);
        check("t1_first_bank", {31'd0, rd_bank}, 32'd0);
        begin
            int n = 0;
            @(negedge clk);
            while (!(rd_valid && rd_last) && n < 600) begin @(negedge clk); n++; end
            check("t1_last_seen", {31'd0, rd_last}, 32'd1);
            check("t1_last_data", {9'd0, rd_data}, 32'd255);
            check("t1_last_idx", {24'd0, rd_idx}, 32'd255);
        end
        wait_drain("t1");

        // T2: illegal values mid-fill, plus the largest legal value.
        start_fill("t2");
        for (int i = 0; i < 100; i++) send(24'(i*3 + 7));
        send(24'h7FE001);
        check("t2_range_err_q", {31'd0, range_err}, 32'd1);
        check("t2_count_after_q", {23'd0, wr_count}, 32'd100);
        send(24'hFFFFFF);
        check("t2_count_after_ff", {23'd0, wr_count}, 32'd100);
        send(24'h7FE000);
        check("t2_count_after_qm1", {23'd0, wr_count}, 32'd101);
        check("t2_range_err_sticky", {31'd0, range_err}, 32'd1);
        for (int i = 0; i < 155; i++) send(24'h400000 + 24'(i));
        wait_drain("t2");

        // T3: ping-pong with the consumer stalled, then W_WAIT and overflow.
        rd_ready = 1'b0;
        start_fill("t3a");
        for (int i = 0; i < N; i++) send(24'(1000 + i));
        start_fill("t3b");
        for (int i = 0; i < N; i++) send(24'(2000 + i));
        start_fill("t3c");
        check("t3_wait_not_ready", {31'd0, wr_ready}, 32'd0);
        send(24'd42);
        check("t3_overflow", {31'd0, overflow}, 32'd1);
        check("t3_wait_count", {23'd0, wr_count}, 32'd0);
        check("t3_stalled_valid", {31'd0, rd_valid}, 32'd1);
        check("t3_stalled_data", {9'd0, rd_data}, 32'd1000);
        rd_ready = 1'b1;
        begin
            int n = 0;
            @(negedge clk);
            while (!(rd_valid && rd_last) && n < 600) begin @(negedge clk); n++; end
            check("t3_bank0_last", {31'd0, rd_bank}, 32'd0);
            @(negedge clk);
            check("t3_bubble", {31'd0, rd_valid}, 32'd0);
            check("t3_wait_still", {31'd0, wr_ready}, 32'd0);
            @(negedge clk);
            check("t3_bank1_valid", {31'd0, rd_valid}, 32'd1);
            check("t3_bank1_bank", {31'd0, rd_bank}, 32'd1);
            check("t3_bank1_data", {9'd0, rd_data}, 32'd2000);
            check("t3_wait_to_fill", {31'd0, wr_ready}, 32'd1);
        end
        m_fill = 1'b1;
        for (int i = 0; i < N; i++) send(24'(3000 + i));
        wait_drain("t3");

        // T4: random backpressure while filling and streaming.
        start_fill("t4");
        fork
            begin
                for (int i = 0; i < N; i++) send(24'(4000 + i*7));
            end
            begin
                int n = 0;
                while ((m_fill || exp_coef.size() != 0) && n < 5000) begin
                    @(posedge clk); #1;
                    rd_ready = 1'($urandom_range(0, 1));
                    n++;
                end
            end
        join
        check("t4_drained", exp_coef.size(), 32'd0);
        rd_ready = 1'b1;
        @(negedge clk);
        check("t4_rd_idle", {31'd0, rd_valid}, 32'd0);

        // T5: abandon a partial fill after 100 writes.
        start_fill("t5");
        for (int i = 0; i < 100; i++) send(24'(5000 + i));
        check("t5_partial_count", {23'd0, wr_count}, 32'd100);
        start_fill("t5b");
        for (int i = 0; i < N; i++) send(24'(6000 + i));
        @(posedge clk); #1;
        check("t5_first_data", {9'd0, rd_data}, 32'd6000);
        wait_drain("t5");

        // T6: reset in mid-stream, then a fresh fill from bank 0.
        start_fill("t6");
        for (int i = 0; i < N; i++) send(24'(7000 + i));
        begin
            int n = 0;
            @(negedge clk);
            while (!(rd_valid && rd_idx == 8'd40) && n < 400) begin @(negedge clk); n++; end
            check("t6_reached_40", {24'd0, rd_idx}, 32'd40);
        end
        @(posedge clk); #1;
        do_reset("t6");
        start_fill("t6b");
        for (int i = 0; i < N; i++) send(24'(8000 + i));
        @(posedge clk); #1;
        check("t6_fresh_bank", {31'd0, rd_bank}, 32'd0);
        check("t6_fresh_data", {9'd0, rd_data}, 32'd8000);
        wait_drain("t6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ntt_poly_buffer.md
# ntt_poly_buffer

Double-buffered (ping-pong) coefficient store downstream of the rejection sampler (RejNTTPoly FSM). Captures the sampler's accepted 24-bit coefficient stream (`z_out`/`z_valid`), range-checks each value against q = 8380417, and packs 256 values into one polynomial bank. It then streams each completed polynomial in index order to the NTT/matrix-multiply stage over a valid/ready handshake, while the sampler fills the other bank.

## Interface
Parameters:
- `N`, 256: coefficients per polynomial; must be a power of 2.
- `IN_W`, 24: sampler coefficient width.
- `COEF_W`, 23: stored and output coefficient width.
- `Q`, 8380417: modulus; values ≥ Q are illegal.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `wr_start`  in  1  1-cycle pulse; request to fill the next bank (driven alongside `start_rej`).
- `z_valid`  in  1  coefficient strobe from the sampler.
- `z_in`  in  IN_W  coefficient from the sampler.
- `wr_ready`  out  1  high while in W_FILL; a write is accepted only in W_FILL.
- `poly_done`  out  1  1-cycle pulse when the N-th coefficient is stored.
- `wr_count`  out  log2(N)+1  coefficients stored in the current fill.
- `overflow`  out  1  sticky: `z_valid` arrived while not in W_FILL, excluding W_IDLE.
- `range_err`  out  1  sticky: `z_in` ≥ Q was received.
- `rd_valid`  out  1  output coefficient valid.
- `rd_ready`  in  1  consumer accepts.
- `rd_data`  out  COEF_W  coefficient.
- `rd_idx`  out  log2(N)  index of `rd_data`.
- `rd_last`  out  1  high with `rd_idx` = N-1.
- `rd_bank`  out  1  bank being read.

## Operation
- Storage: 2×N×COEF_W register array. Per-bank `full` flag. `fill_bank` and `read_bank` pointers both start at bank 0 and toggle independently.
- Write FSM, states W_IDLE, W_WAIT, W_FILL:
  - W_IDLE + `wr_start`: go to W_FILL if `full[fill_bank]`=0, otherwise go to W_WAIT. Clear `wr_count`, `overflow` and `range_err`.
  - W_WAIT → W_FILL when `full[fill_bank]` clears.
  - W_FILL + `z_valid`:
    - If `z_in` < Q: write `z_in[COEF_W-1:0]` to `mem[fill_bank][wr_count]` and increment `wr_count`.
    - If `z_in` ≥ Q: drop it, set `range_err`, leave `wr_count` unchanged.
  - N-th accepted write: set `full[fill_bank]`, pulse `poly_done`, toggle `fill_bank`, go to W_IDLE.
  - `wr_start` in W_FILL or W_WAIT: abandon the partial fill. Reset `wr_count` to 0, reuse the same `fill_bank`, re-evaluate as if from W_IDLE. Bank contents stay stale until overwritten.
  - `z_valid` in W_WAIT sets `overflow`; the data is dropped. `z_valid` in W_IDLE is ignored silently.
- Read FSM, states R_IDLE, R_STREAM:
  - R_IDLE with `full[read_bank]`=1 → R_STREAM. Load `rd_data` = `mem[read_bank][0]`, set `rd_idx` = 0, `rd_valid` = 1.
  - R_STREAM, on `rd_valid`&&`rd_ready`: load the next index (registered output, so throughput is 1 per cycle).
  - Handshake with `rd_last`: clear `full[read_bank]`, toggle `read_bank`, deassert `rd_valid`, go to R_IDLE.
  - `rd_data`, `rd_idx` and `rd_last` hold stable while `rd_valid`=1 and `rd_ready`=0.
- Simultaneous events:
  - Final read handshake of bank X and `full[X]`-dependent W_WAIT in the same cycle: W_WAIT sees the cleared flag on the following cycle. No same-cycle bypass.
  - N-th write to bank A and final read of bank B in the same cycle: both complete; both flags update independently.
- Reset: all outputs are 0, both banks empty, both pointers 0, both FSMs idle. Array contents are not cleared.

## Timing
- `wr_start` at edge E → W_FILL (`wr_ready`=1) after E when the bank is free. Writes are sampled from the cycle after E.
- N-th write at edge W → `poly_done`=1 for the cycle after W, and `full` is set after W. Read FSM loads at W+1, so `rd_valid`=1 from W+1.
- Final read handshake at edge F → `rd_valid`=0 after F. The next bank can start streaming at F+1 at the earliest, giving a 1-cycle bubble.
- `wr_count` arithmetic is unsigned and saturates logically at N; it never wraps because the FSM leaves W_FILL at N.

## Test plan
- Reset, then `wr_start` and 256 writes of z = 0..255 with `rd_ready`=1:
  - `poly_done` pulses once.
  - `rd_valid` rises one cycle later.
  - The stream gives `rd_idx`/`rd_data` = 0..255, `rd_bank`=0, and `rd_last` at index 255.
- Inject `z_in` = 0x7FE001 and 0xFFFFFF mid-fill: `range_err`=1, `wr_count` unchanged, and the 256 valid values stream in order.
- Ping-pong: fill bank 0 with `rd_ready`=0, `wr_start` again, fill bank 1 fully.
  - Both `full` flags set.
  - A third `wr_start` goes to W_WAIT; `z_valid` there sets `overflow`.
  - Releasing `rd_ready` drains bank 0, then (after the 1-cycle bubble) bank 1, and the third fill proceeds into bank 0.
- Random `rd_ready` backpressure: `rd_data`/`rd_idx` stable while stalled; no duplicates or skips over 256 coefficients.
- `wr_start` after 100 writes: `wr_count` returns to 0, and only the subsequent 256 values appear at the output.
- `rst` asserted mid-stream at index 40: all outputs are 0 next cycle; a fresh fill then streams correctly from bank 0.
